// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and grant encoding for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2
  } gnt_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small FIFO for long-latency writebacks; one-cycle write-to-head latency, push ignored when full.
// Exposes every entry's valid bit and rd so the owner can build a pending-write mask.
module wb_fifo #(
  parameter int  DATA_W = 32,
  parameter int  ADDR_W = 5,
  parameter int  DEPTH  = 2,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_rd,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [CW-1:0]            count,
  output logic [ADDR_W-1:0]        head_rd,
  output logic [DATA_W-1:0]        head_data,
  output logic [DEPTH-1:0]         ent_vld,
  output logic [DEPTH*ADDR_W-1:0]  ent_rd
);
  import regfile_wb_arbiter_pkg::*;

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_mem_q  [DEPTH];
  logic [ADDR_W-1:0] rd_mem_d  [DEPTH];
  logic [DATA_W-1:0] dat_mem_q [DEPTH];
  logic [DATA_W-1:0] dat_mem_d [DEPTH];
  logic              is_full, is_empty, do_push, do_pop;
  logic [PW-1:0]     off;

  assign is_empty  = (cnt_q == '0);
  assign is_full   = (cnt_q == CW'(DEPTH));
  assign do_push   = push && !is_full;
  assign do_pop    = pop && !is_empty;
  assign count     = cnt_q;
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = dat_mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    rd_mem_d  = rd_mem_q;
    dat_mem_d = dat_mem_q;
    if (do_push) begin
      rd_mem_d[wr_ptr_q]  = push_rd;
      dat_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    off     = '0;
    ent_vld = '0;
    ent_rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off                         = PW'(i) - rd_ptr_q;
      ent_vld[i]                  = (CW'(off) < cnt_q);
      ent_rd[i*ADDR_W +: ADDR_W]  = rd_mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_mem_q  <= rd_mem_d;
    dat_mem_q <= dat_mem_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (P0) and a queued long-latency unit (P1).
// rf_* are registered (one cycle after grant); P1 backpressured by FIFO full, P0 stalled only on P1 starvation.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_rd,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_stall,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_rd,
  input  logic [DATA_W-1:0] p1_data,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_data,
  output logic [31:0]       pending_mask
);
  import regfile_wb_arbiter_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0]                count;
  logic [ADDR_W-1:0]            head_rd;
  logic [DATA_W-1:0]            head_data;
  logic [FIFO_DEPTH-1:0]        ent_vld;
  logic [FIFO_DEPTH*ADDR_W-1:0] ent_rd;
  logic                         full, empty, push, pop, starve;
  gnt_e                         gnt;

  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              rf_en_q, rf_en_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign starve   = !empty && (wait_cnt_q >= WW'(MAX_WAIT));
  // No same-cycle pop credit: a full queue refuses even when its head leaves this cycle.
  assign p1_ready = !full && !rst;
  assign push     = p1_valid && p1_ready;
  assign pop      = (gnt == GNT_P1);
  assign p0_stall = starve && p0_valid && !rst;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (p1_rd),
    .push_data (p1_data),
    .pop       (pop),
    .count     (count),
    .head_rd   (head_rd),
    .head_data (head_data),
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (starve) begin
      gnt = GNT_P1;
    end else if (p0_valid) begin
      gnt = GNT_P0;
    end else if (!empty) begin
      gnt = GNT_P1;
    end
  end

  always_comb begin
    rf_en_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_data_d  = rf_data_q;
    wait_cnt_d = wait_cnt_q;
    case (gnt)
      GNT_P0: begin
        rf_en_d   = 1'b1;
        rf_rd_d   = p0_rd;
        rf_data_d = p0_data;
      end
      GNT_P1: begin
        rf_en_d   = 1'b1;
        rf_rd_d   = head_rd;
        rf_data_d = head_data;
      end
      default: ;
    endcase
    if (empty || pop) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rf_en_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_data_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rf_en_q    <= rf_en_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign rf_en   = rf_en_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i]) begin
        pending_mask[ent_rd[i*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    if (rf_en_q) begin
      pending_mask[rf_rd_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_stall, p1_valid, p1_ready, rf_en;
  logic [4:0]  p0_rd, p1_rd, rf_rd;
  logic [31:0] p0_data, p1_data, rf_data, pending_mask;
  logic [31:0] shadow [32];
  int          checks = 0;
  int          errors = 0;

  regfile_wb_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .FIFO_DEPTH (DEPTH),
    .MAX_WAIT   (MAXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_valid     (p0_valid),
    .p0_rd        (p0_rd),
    .p0_data      (p0_data),
    .p0_stall     (p0_stall),
    .p1_valid     (p1_valid),
    .p1_ready     (p1_ready),
    .p1_rd        (p1_rd),
    .p1_data      (p1_data),
    .rf_en        (rf_en),
    .rf_rd        (rf_rd),
    .rf_data      (rf_data),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  // Register-file image built from what the arbiter actually writes.
  always @(posedge clk) begin
    if (rf_en === 1'b1) shadow[rf_rd] <= rf_data;
  end

  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    p0_valid = v0; p0_rd = r0; p0_data = d0;
    p1_valid = v1; p1_rd = r1; p1_data = d1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22);
    repeat (2) begin
      @(negedge clk); #1;
      checks++; if (p1_ready !== 1'b0) begin errors++; $display("FAIL reset_p1_ready got %b exp 0", p1_ready); end
      checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL reset_rf_en got %b exp 0", rf_en); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", pending_mask); end
      checks++; if (p0_stall !== 1'b0) begin errors++; $display("FAIL reset_p0_stall got %b exp 0", p0_stall); end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL release_p1_ready got %b exp 1", p1_ready); end
    checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL release_rf_en got %b exp 0", rf_en); end
    @(negedge clk); #1;
    checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL release_spurious_write got %b exp 0", rf_en); end
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL release_mask got %h exp 0", pending_mask); end
  endtask

  task automatic test_p0_only();
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'h0); #1;
    checks++; if (p0_stall !== 1'b0) begin errors++; $display("FAIL p0_stall_a got %b exp 0", p0_stall); end
    @(negedge clk);
    drive(1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0); #1;
    checks++; if (p0_stall !== 1'b0) begin errors++; $display("FAIL p0_stall_b got %b exp 0", p0_stall); end
    checks++; if ({rf_en, rf_rd, rf_data} !== {1'b1, 5'd3, 32'h1234_5678})
      begin errors++; $display("FAIL p0_write_r3 got en=%b rd=%0d data=%h exp en=1 rd=3 data=12345678", rf_en, rf_rd, rf_data); end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); #1;
    checks++; if ({rf_en, rf_rd, rf_data} !== {1'b1, 5'd4, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL p0_write_r4 got en=%b rd=%0d data=%h exp en=1 rd=4 data=deadbeef", rf_en, rf_rd, rf_data); end
    @(negedge clk); #1;
    checks++; if ({rf_en, rf_rd, rf_data} !== {1'b0, 5'd4, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL p0_idle_hold got en=%b rd=%0d data=%h exp en=0 rd=4 data=deadbeef", rf_en, rf_rd, rf_data); end
  endtask

  task automatic test_p1_only();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hA5A5_A5A5); #1;
    checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL p1_accept_ready got %b exp 1", p1_ready); end
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL p1_mask_pre got %h exp 0", pending_mask); end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); #1;
    checks++; if (pending_mask !== 32'h80) begin errors++; $display("FAIL p1_mask_queued got %h exp 80", pending_mask); end
    checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL p1_no_bypass got %b exp 0", rf_en); end
    @(negedge clk); #1;
    checks++; if ({rf_en, rf_rd, rf_data} !== {1'b1, 5'd7, 32'hA5A5_A5A5})
      begin errors++; $display("FAIL p1_write_r7 got en=%b rd=%0d data=%h exp en=1 rd=7 data=a5a5a5a5", rf_en, rf_rd, rf_data); end
    checks++; if (pending_mask !== 32'h80) begin errors++; $display("FAIL p1_mask_rf got %h exp 80", pending_mask); end
    @(negedge clk); #1;
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL p1_mask_post got %h exp 0", pending_mask); end
  endtask

  task automatic test_backpressure();
    logic [4:0]  seen_rd [$];
    logic [31:0] seen_d  [$];
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0)      drive(1'b1, 5'd1, 32'h0000_0111, 1'b1, 5'd9,  32'h0000_0099);
      else if (i == 1) drive(1'b1, 5'd1, 32'h0000_0111, 1'b1, 5'd10, 32'h0000_1010);
      else             drive(1'b1, 5'd1, 32'h0000_0111, 1'b0, 5'd0,  32'h0);
      #1;
      if (i == 2) begin
        checks++; if (p1_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", p1_ready); end
      end
      checks++;
      if (p0_stall !== ((i == 5) || (i == 10))) begin
        errors++; $display("FAIL bp_stall cycle %0d got %b exp %b", i, p0_stall, (i == 5) || (i == 10));
      end
      if (rf_en === 1'b1 && rf_rd !== 5'd1) begin
        seen_rd.push_back(rf_rd);
        seen_d.push_back(rf_data);
      end
    end
    checks++;
    if (seen_rd.size() != 2) begin
      errors++; $display("FAIL bp_p1_write_count got %0d exp 2", seen_rd.size());
    end else begin
      checks++; if ({seen_rd[0], seen_d[0]} !== {5'd9, 32'h0000_0099})
        begin errors++; $display("FAIL bp_first_write got rd=%0d data=%h exp rd=9 data=99", seen_rd[0], seen_d[0]); end
      checks++; if ({seen_rd[1], seen_d[1]} !== {5'd10, 32'h0000_1010})
        begin errors++; $display("FAIL bp_second_write got rd=%0d data=%h exp rd=10 data=1010", seen_rd[1], seen_d[1]); end
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_push_pop();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB0B0_0011); #1;
    checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL pp_first_ready got %b exp 1", p1_ready); end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0C0_0012); #1;
    checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL pp_second_ready got %b exp 1", p1_ready); end
    checks++; if (pending_mask !== 32'h0000_0800) begin errors++; $display("FAIL pp_mask_one got %h exp 800", pending_mask); end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); #1;
    checks++; if ({rf_en, rf_rd, rf_data} !== {1'b1, 5'd11, 32'hB0B0_0011})
      begin errors++; $display("FAIL pp_write_r11 got en=%b rd=%0d data=%h exp en=1 rd=11 data=b0b00011", rf_en, rf_rd, rf_data); end
    checks++; if (pending_mask !== 32'h0000_1800) begin errors++; $display("FAIL pp_mask_both got %h exp 1800", pending_mask); end
    @(negedge clk); #1;
    checks++; if ({rf_en, rf_rd, rf_data} !== {1'b1, 5'd12, 32'hC0C0_0012})
      begin errors++; $display("FAIL pp_write_r12 got en=%b rd=%0d data=%h exp en=1 rd=12 data=c0c00012", rf_en, rf_rd, rf_data); end
    checks++; if (pending_mask !== 32'h0000_1000) begin errors++; $display("FAIL pp_mask_last got %h exp 1000", pending_mask); end
    @(negedge clk); #1;
    checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL pp_drain got %b exp 0", rf_en); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk); drive(1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 32'h0);
    @(negedge clk); drive(1'b1, 5'd6, 32'h0000_0066, 1'b0, 5'd0, 32'h0);
    @(negedge clk); drive(1'b1, 5'd1, 32'h0101_0101, 1'b1, 5'd5, 32'hBAD0_0005);
    @(negedge clk); drive(1'b1, 5'd1, 32'h0101_0101, 1'b1, 5'd6, 32'hBAD0_0006);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); #1;
    checks++; if (pending_mask !== 32'h0000_0062) begin errors++; $display("FAIL mr_mask_before got %h exp 62", pending_mask); end
    checks++; if (p1_ready !== 1'b0) begin errors++; $display("FAIL mr_ready_in_rst got %b exp 0", p1_ready); end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL mr_mask_after got %h exp 0", pending_mask); end
    checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL mr_rf_en_after got %b exp 0", rf_en); end
    repeat (4) begin
      @(negedge clk); #1;
      checks++; if (rf_en !== 1'b0) begin errors++; $display("FAIL mr_late_write got en=%b rd=%0d exp en=0", rf_en, rf_rd); end
    end
    checks++; if (shadow[5] !== 32'h0000_0055) begin errors++; $display("FAIL mr_r5 got %h exp 55", shadow[5]); end
    checks++; if (shadow[6] !== 32'h0000_0066) begin errors++; $display("FAIL mr_r6 got %h exp 66", shadow[6]); end
  endtask

  task automatic test_random();
    ent_t        mq [$];
    ent_t        h;
    int          m_wait, n;
    logic        m_en, prev_stall, take_p1, e_ready, e_stall;
    logic [4:0]  m_rd;
    logic [31:0] m_data, e_mask;
    m_wait = 0; m_en = 1'b0; m_rd = '0; m_data = '0; prev_stall = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = (c == 0) || ($urandom_range(0, 59) == 0);
      if (!(prev_stall && p0_valid)) begin
        p0_valid = ($urandom_range(0, 9) < 7);
        p0_rd    = 5'($urandom_range(0, 31));
        p0_data  = $urandom;
      end
      p1_valid = ($urandom_range(0, 9) < 5);
      p1_rd    = 5'($urandom_range(0, 31));
      p1_data  = $urandom;
      #1;
      e_ready = !rst && (mq.size() < DEPTH);
      e_stall = !rst && p0_valid && (mq.size() > 0) && (m_wait >= MAXW);
      e_mask  = '0;
      foreach (mq[k]) e_mask[mq[k].rd] = 1'b1;
      if (m_en) e_mask[m_rd] = 1'b1;
      if (c > 0) begin
        checks++; if (p1_ready !== e_ready) begin errors++; $display("FAIL rnd_p1_ready cyc %0d got %b exp %b", c, p1_ready, e_ready); end
        checks++; if (p0_stall !== e_stall) begin errors++; $display("FAIL rnd_p0_stall cyc %0d got %b exp %b", c, p0_stall, e_stall); end
        checks++; if ({rf_en, rf_rd, rf_data} !== {m_en, m_rd, m_data})
          begin errors++; $display("FAIL rnd_rf cyc %0d got en=%b rd=%0d data=%h exp en=%b rd=%0d data=%h", c, rf_en, rf_rd, rf_data, m_en, m_rd, m_data); end
        checks++; if (pending_mask !== e_mask) begin errors++; $display("FAIL rnd_mask cyc %0d got %h exp %h", c, pending_mask, e_mask); end
      end
      prev_stall = e_stall;
      // Advance the reference to the state after this cycle's rising edge.
      if (rst) begin
        mq.delete(); m_wait = 0; m_en = 1'b0; m_rd = '0; m_data = '0;
      end else begin
        n       = mq.size();
        take_p1 = (n > 0) && ((m_wait >= MAXW) || !p0_valid);
        if (take_p1) begin
          h = mq.pop_front(); m_en = 1'b1; m_rd = h.rd; m_data = h.d; m_wait = 0;
        end else begin
          m_en = p0_valid;
          if (p0_valid) begin m_rd = p0_rd; m_data = p0_data; end
          if (n == 0) m_wait = 0;
          else if (m_wait < MAXW) m_wait++;
        end
        if (p1_valid && n < DEPTH) mq.push_back('{rd: p1_rd, d: p1_data});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_p0_only();
    test_p1_only();
    test_backpressure();
    test_push_pop();
    test_mid_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
